bcd_to_binary: RTL

//   Sequential BCD-to-binary converter: the inverse of binary_to_bcd (reverse double-dabble).

---
 rtl/bcd_to_binary_pkg.sv | 13 +
 rtl/bcd_digit_adjust.sv | 10 +
 rtl/bcd_to_binary.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encodings and
// the largest legal BCD digit.
package bcd_to_binary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction: a digit that reads 8 or more after the
// right shift had a tens carry folded in and must drop by 3.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = digit_i[3] ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Iterative packed-BCD to binary converter: one shift/adjust step per clock,
// start/done handshake, error flag for non-decimal digits and overflow flag.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      binary_out,
  output logic                  error,
  output logic                  overflow
);

  localparam int NB = 4 * DIGITS;
  localparam int CW = $clog2(NB) + 1;

  state_e            state_q, state_d;
  logic [NB-1:0]     bcd_q, bcd_d;
  logic [NB-1:0]     bin_q, bin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  binary_out_q, binary_out_d;
  logic              error_q, error_d;
  logic              overflow_q, overflow_d;

  logic [NB-1:0]     bcd_sh, bcd_adj, bin_sh;
  logic              in_invalid;
  logic              bin_ovf;

  // The whole {bcd, bin} pair moves right one bit per step.
  assign bcd_sh = {1'b0, bcd_q[NB-1:1]};
  assign bin_sh = {bcd_q[0], bin_q[NB-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (bcd_sh[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  if (WIDTH < NB) begin : g_ovf
    assign bin_ovf = |bin_sh[NB-1:WIDTH];
  end else begin : g_no_ovf
    assign bin_ovf = 1'b0;
  end

  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) in_invalid = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    bcd_d        = bcd_q;
    bin_d        = bin_q;
    cnt_d        = cnt_q;
    binary_out_d = binary_out_q;
    error_d      = error_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (in_invalid) begin
            // Result and overflow keep the last good conversion.
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            bcd_d   = bcd_in;
            bin_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NB - 1)) begin
          state_d      = ST_DONE;
          binary_out_d = bin_sh[WIDTH-1:0];
          overflow_d   = bin_ovf;
          error_d      = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bcd_q        <= '0;
      bin_q        <= '0;
      cnt_q        <= '0;
      binary_out_q <= '0;
      error_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcd_q        <= bcd_d;
      bin_q        <= bin_d;
      cnt_q        <= cnt_d;
      binary_out_q <= binary_out_d;
      error_q      <= error_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign binary_out = binary_out_q;
  assign error      = error_q;
  assign overflow   = overflow_q;

endmodule
